// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for an instruction fetch port.
// Generates word-aligned fetch addresses with a valid/ready handshake, takes
// branch/jump redirects through a one-cycle FLUSH bubble, and wraps modulo 2^32.
// Optional feature macro: PC_MISALIGN_TRAP_EN. When it is defined, a misaligned
// redirect target loads TRAP_VEC and raises a one-cycle Trap pulse. When it is
// undefined, the low two target bits are dropped and Trap is tied low.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic        Clk,
  input  logic        Reset,          // synchronous, active-low
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic        FetchReady,
  output logic        FetchValid,
  output logic [31:0] PCResult,
  output logic [31:0] PCAddResult,
  output logic        Trap
);

  // Low two address bits are forced to zero everywhere a PC is loaded.
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_pc;

`ifdef PC_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  logic redirect_misaligned;

  // Resolve the redirect destination: misaligned targets divert to the trap vector.
  always_comb begin
    redirect_misaligned = (RedirectTarget[1:0] != 2'b00);
    redirect_pc         = redirect_misaligned ? (TRAP_VEC & WORD_MASK)
                                              : (RedirectTarget & WORD_MASK);
  end
`else
  // Resolve the redirect destination: the low two target bits are simply dropped.
  always_comb begin
    redirect_pc = RedirectTarget & WORD_MASK;
  end
`endif

  // Next-state and next-PC logic; every path starts from "hold".
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_MISALIGN_TRAP_EN
    trap_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Redirect is deliberately ignored here; no request is outstanding.
        state_d = FETCH;
      end
      FETCH: begin
        if (Redirect) begin
          // Redirect wins over an accepted transfer; the current address still
          // counts as transferred if FetchReady is high, but is abandoned otherwise.
          pc_d    = redirect_pc;
          state_d = FLUSH;
`ifdef PC_MISALIGN_TRAP_EN
          trap_d  = redirect_misaligned;
`endif
        end else if (FetchReady) begin
          pc_d = pc_q + 32'd4;   // wraps silently at 2^32
        end
      end
      FLUSH: begin
        if (Redirect) begin
          // A redirect inside the bubble restarts it with the new target.
          pc_d    = redirect_pc;
          state_d = FLUSH;
`ifdef PC_MISALIGN_TRAP_EN
          trap_d  = redirect_misaligned;
`endif
        end else begin
          state_d = FETCH;
        end
      end
      default: begin
        // Unused encoding: recover to IDLE.
        state_d = IDLE;
      end
    endcase
  end

  // State, PC and trap registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC & WORD_MASK;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  // Outputs are decoded directly from the registers.
  always_comb begin
    FetchValid  = (state_q == FETCH);
    PCResult    = pc_q;
    PCAddResult = pc_q + 32'd4;
`ifdef PC_MISALIGN_TRAP_EN
    Trap        = trap_q;
`else
    Trap        = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: a behavioural reference model predicts the
// outputs after each clock edge; predictions are queued when stimulus is
// driven and popped/compared one edge later. Directed checks cover reset,
// backpressure, redirect, wrap, misaligned redirect and reset-in-FLUSH,
// followed by a constrained-random run.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0080;

  logic        Clk;
  logic        Reset;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        FetchReady;
  logic        FetchValid;
  logic [31:0] PCResult;
  logic [31:0] PCAddResult;
  logic        Trap;

  pc_sequencer #(
    .RESET_PC (RESET_PC),
    .TRAP_VEC (TRAP_VEC)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .FetchReady     (FetchReady),
    .FetchValid     (FetchValid),
    .PCResult       (PCResult),
    .PCAddResult    (PCAddResult),
    .Trap           (Trap)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        fv;
    logic [31:0] pc;
    logic [31:0] pa;
    logic        tr;
  } exp_t;

  exp_t exp_q[$];

  int checks_cnt   = 0;
  int failures_cnt = 0;

  // Reference model state: 0=IDLE 1=FETCH 2=FLUSH
  int          mdl_state = 0;
  logic [31:0] mdl_pc    = RESET_PC;
  logic        mdl_trap  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks_cnt++;
    if (obs !== expv) begin
      failures_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic mdl_load(input logic [31:0] tgt);
`ifdef PC_MISALIGN_TRAP_EN
    if (tgt[1:0] != 2'b00) begin
      mdl_pc   = TRAP_VEC;
      mdl_trap = 1'b1;
    end else begin
      mdl_pc = {tgt[31:2], 2'b00};
    end
`else
    mdl_pc = {tgt[31:2], 2'b00};
`endif
  endtask

  // One clock cycle: drive inputs, predict, push, wait for the edge, pop and compare.
  task automatic step(input logic rst_n, input logic redir, input logic [31:0] tgt, input logic rdy);
    exp_t e;
    exp_t got;
    @(negedge Clk);
    Reset          = rst_n;
    Redirect       = redir;
    RedirectTarget = tgt;
    FetchReady     = rdy;
    mdl_trap = 1'b0;
    if (!rst_n) begin
      mdl_state = 0;
      mdl_pc    = RESET_PC;
    end else begin
      case (mdl_state)
        0: mdl_state = 1;
        1: begin
          if (redir) begin
            mdl_load(tgt);
            mdl_state = 2;
          end else if (rdy) begin
            mdl_pc = mdl_pc + 32'd4;
          end
        end
        default: begin
          if (redir) mdl_load(tgt);
          else       mdl_state = 1;
        end
      endcase
    end
    e.fv = (mdl_state == 1);
    e.pc = mdl_pc;
    e.pa = mdl_pc + 32'd4;
    e.tr = mdl_trap;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    got = exp_q.pop_front();
    $display("txn rst=%0b redir=%0b tgt=%08h rdy=%0b -> fv=%0b pc=%08h pa=%08h trap=%0b",
             rst_n, redir, tgt, rdy, FetchValid, PCResult, PCAddResult, Trap);
    check("fetch_valid", {31'd0, FetchValid}, {31'd0, got.fv});
    check("pc_result",   PCResult,            got.pc);
    check("pc_add",      PCAddResult,         got.pa);
    check("trap",        {31'd0, Trap},       {31'd0, got.tr});
  endtask

  initial begin
    Reset          = 1'b0;
    Redirect       = 1'b0;
    RedirectTarget = 32'd0;
    FetchReady     = 1'b0;

    // Reset held low for three cycles, with noise on the other inputs.
    step(1'b0, 1'b1, 32'h0000_1234, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    check("rst_fv",  {31'd0, FetchValid}, 32'd0);
    check("rst_pc",  PCResult, 32'h0);

    // Release: first fetch address is RESET_PC, then +4 steps.
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("rel_pc0", PCResult, 32'h0);
    check("rel_pa0", PCAddResult, 32'h4);
    check("rel_fv0", {31'd0, FetchValid}, 32'd1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("rel_pc1", PCResult, 32'h4);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("rel_pc2", PCResult, 32'h8);
    check("rel_pa2", PCAddResult, 32'hC);

    // Advance to 0x10, then four cycles of backpressure.
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b0);
      check("bp_hold", PCResult, 32'h10);
    end
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("bp_release", PCResult, 32'h14);

    // Advance to 0x20 and redirect to 0x400.
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("pre_redir_pc", PCResult, 32'h20);
    step(1'b1, 1'b1, 32'h0000_0400, 1'b1);
    check("flush_fv", {31'd0, FetchValid}, 32'd0);
    check("flush_pc", PCResult, 32'h400);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("post_flush_fv", {31'd0, FetchValid}, 32'd1);
    check("post_flush_pc", PCResult, 32'h400);

    // Redirect while in FLUSH restarts the bubble.
    step(1'b1, 1'b1, 32'h0000_0800, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0900, 1'b0);
    check("flush_redir_pc", PCResult, 32'h900);
    step(1'b1, 1'b0, 32'd0, 1'b0);

    // Wrap at the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    check("wrap_pa", PCAddResult, 32'h0);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("wrap_pc", PCResult, 32'h0);
    check("wrap_trap", {31'd0, Trap}, 32'd0);

    // Misaligned redirect.
    step(1'b1, 1'b1, 32'h0000_0403, 1'b1);
`ifdef PC_MISALIGN_TRAP_EN
    check("mis_pc",   PCResult, 32'h80);
    check("mis_trap", {31'd0, Trap}, 32'd1);
`else
    check("mis_pc",   PCResult, 32'h400);
    check("mis_trap", {31'd0, Trap}, 32'd0);
`endif
    step(1'b1, 1'b0, 32'd0, 1'b1);
    check("mis_trap_end", {31'd0, Trap}, 32'd0);

    // Reset during FLUSH with Redirect asserted.
    step(1'b1, 1'b1, 32'h0000_0500, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0600, 1'b1);
    check("rst_flush_pc", PCResult, RESET_PC);
    check("rst_flush_fv", {31'd0, FetchValid}, 32'd0);
    // Redirect is ignored in IDLE.
    step(1'b1, 1'b1, 32'h0000_0700, 1'b1);
    check("idle_ignore_pc", PCResult, RESET_PC);

    // Constrained-random traffic.
    for (int i = 0; i < 300; i++) begin
      logic        r_rst;
      logic        r_red;
      logic [31:0] r_tgt;
      logic        r_rdy;
      r_rst = ($urandom_range(0, 19) != 0);
      r_red = ($urandom_range(0, 3) == 0);
      r_tgt = $urandom;
      if ($urandom_range(0, 1) == 0) r_tgt[1:0] = 2'b00;
      r_rdy = ($urandom_range(0, 2) != 0);
      step(r_rst, r_red, r_tgt, r_rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
